// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: FSM state encoding and lamp colours.
// TRAFFIC_NIGHT_FLASH_EN adds the FLASH state.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6
`ifdef TRAFFIC_NIGHT_FLASH_EN
        ,
        FLASH     = 3'd7
`endif
    } state_t;

    // Lamp triplets are {R,G,B}; yellow is red+green.
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] OFF    = 3'b000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Phase-timing prescaler: one-cycle tick every TICK_DIV clocks.
module traffic_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/traffic_ctrl.sv
// Two-approach intersection controller with pedestrian walk phase.
// Define TRAFFIC_NIGHT_FLASH_EN for the night-mode flashing-yellow state and night input.
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_DIV = 100_000_000,
    parameter int GREEN_T  = 5,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1,
    parameter int WALK_T   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [2:0] ns_rgb,
    output logic [2:0] ew_rgb,
    output logic       walk,
    output logic       ped_wait,
    output logic [2:0] phase
);

    localparam int MAXD = max2(max2(GREEN_T, YELLOW_T), max2(ALLRED_T, WALK_T));
    localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    if (CLK_FREQ < TICK_DIV) begin : g_bad_cfg
        $error("traffic_ctrl: TICK_DIV exceeds CLK_FREQ");
    end

    logic          tick;
    state_t        state, nxt;
    logic [CW-1:0] phase_cnt, dur_m1;
    logic          done, rise;
    logic          req_s1, req_s2, req_d;
    logic          ped_pending, next_dir;

    traffic_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ped_req is asynchronous; req_d holds the previous synchronized level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
            req_d  <= 1'b0;
        end else begin
            req_s1 <= ped_req;
            req_s2 <= req_s1;
            req_d  <= req_s2;
        end
    end

    assign rise = req_s2 & ~req_d;

`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic night_s1, night_s;
    always_ff @(posedge clk) begin
        if (rst) begin
            night_s1 <= 1'b0;
            night_s  <= 1'b0;
        end else begin
            night_s1 <= night;
            night_s  <= night_s1;
        end
    end
`endif

    always_comb begin
        dur_m1 = CW'(ALLRED_T - 1);
        case (state)
            NS_GREEN, EW_GREEN:   dur_m1 = CW'(GREEN_T - 1);
            NS_YELLOW, EW_YELLOW: dur_m1 = CW'(YELLOW_T - 1);
            PED_WALK:             dur_m1 = CW'(WALK_T - 1);
            default:              dur_m1 = CW'(ALLRED_T - 1);
        endcase
    end

    assign done = tick && (phase_cnt == dur_m1);

    always_comb begin
        nxt = state;
        case (state)
            NS_GREEN:  if (done) nxt = NS_YELLOW;
            NS_YELLOW: if (done) nxt = ALLRED_A;
            EW_GREEN:  if (done) nxt = EW_YELLOW;
            EW_YELLOW: if (done) nxt = ALLRED_B;
            ALLRED_A, ALLRED_B: if (done) begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
                if (night_s)          nxt = FLASH;
                else
`endif
                if (ped_pending)      nxt = PED_WALK;
                else if (state == ALLRED_A) nxt = EW_GREEN;
                else                  nxt = NS_GREEN;
            end
            PED_WALK:  if (done) nxt = next_dir ? EW_GREEN : NS_GREEN;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH:     if (tick && !night_s) nxt = ALLRED_B;
`endif
            default:   nxt = ALLRED_B;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ALLRED_B;
        else     state <= nxt;
    end

    // next_dir remembers which green the walk phase displaced (1 = EW).
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt   <= '0;
            next_dir    <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            if (nxt != state) phase_cnt <= '0;
            else if (tick)    phase_cnt <= phase_cnt + 1'b1;

            if (done && state == ALLRED_A) next_dir <= 1'b1;
            if (done && state == ALLRED_B) next_dir <= 1'b0;

            if (nxt == PED_WALK && state != PED_WALK) ped_pending <= 1'b0;
            else if (rise && state != PED_WALK)       ped_pending <= 1'b1;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            if (state == FLASH || nxt == FLASH) ped_pending <= 1'b0;
`endif
        end
    end

    always_comb begin
        ns_rgb = RED;
        ew_rgb = RED;
        walk   = 1'b0;
        case (state)
            NS_GREEN:  ns_rgb = GREEN;
            NS_YELLOW: ns_rgb = YELLOW;
            EW_GREEN:  ew_rgb = GREEN;
            EW_YELLOW: ew_rgb = YELLOW;
            PED_WALK:  walk   = 1'b1;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            // phase_cnt counts ticks within FLASH, so its LSB gives the blink phase.
            FLASH: begin
                ns_rgb = phase_cnt[0] ? OFF : YELLOW;
                ew_rgb = phase_cnt[0] ? OFF : YELLOW;
            end
`endif
            default: ;
        endcase
    end

    assign ped_wait = ped_pending;
    assign phase    = state;

endmodule
